// File: rtl/nachi_pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : nachi_pc_pkg
//  Purpose : Shared types and constants for the nachi7 fetch-stage program
//            counter sequencer (next-PC source select, sequencer state,
//            sequential increment).
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package nachi_pc_pkg;

  // Source chosen for the next PC when a redirect is requested.
  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } pc_sel_t;

  // RUN: normal fetch. PENDING: a redirect arrived under stall and waits.
  typedef enum logic {
    RUN     = 1'b0,
    PENDING = 1'b1
  } pc_state_t;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage : nachi_pc_pkg
`default_nettype wire

// File: rtl/branch_target_calc.sv
`default_nettype none
// ============================================================================
//  Module  : branch_target_calc
//  Purpose : Purely combinational redirect-target arithmetic for the fetch
//            stage. Produces the conditional-branch, J/JAL and JR/JALR
//            targets; selection and sequencing live in pc_sequencer.
//  Ports   :
//    id_pc_plus4  in  32  PC+4 of the instruction in ID
//    imm16        in  16  branch word offset (signed)
//    addr26       in  26  jump word index
//    jr_target    in  32  register value for JR/JALR
//    br_target    out 32  id_pc_plus4 + sign_extend(imm16) << 2
//    j_target     out 32  {id_pc_plus4[31:28], addr26, 2'b00}
//    jr_tgt_al    out 32  jr_target with the low two bits forced to zero
//  Rev     : 1.0  initial release
// ============================================================================
module branch_target_calc
  import nachi_pc_pkg::*;
(
  input  logic [31:0] id_pc_plus4,
  input  logic [15:0] imm16,
  input  logic [25:0] addr26,
  input  logic [31:0] jr_target,
  output logic [31:0] br_target,
  output logic [31:0] j_target,
  output logic [31:0] jr_tgt_al
);

  logic [31:0] br_offset;

  // Word offset: sign-extend to 30 bits, then append two zero bits.
  assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};

  // Addition is modulo 2^32; carry out is intentionally dropped.
  assign br_target = id_pc_plus4 + br_offset;

  // Jump stays inside the current 256 MB region of the delay-slot PC.
  assign j_target  = {id_pc_plus4[31:28], addr26, 2'b00};

  // Fetch always uses a word-aligned address; misalignment is reported
  // separately by the sequencer.
  assign jr_tgt_al = {jr_target[31:2], 2'b00};

endmodule : branch_target_calc
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : pc_sequencer
//  Purpose : Owns the nachi7 program counter. Selects the next fetch address
//            among sequential, branch, jump and register-jump targets,
//            holds under stall, defers redirects that arrive while stalled,
//            and pulses a one-cycle IF flush on every taken redirect.
//  Ports   :
//    clk          in   1  system clock, rising edge
//    rst_n        in   1  asynchronous active-low reset
//    stall        in   1  hazard stall; PC holds while high
//    br_valid     in   1  ID instruction is a conditional branch
//    br_taken     in   1  branch condition true (qualified by br_valid)
//    j_valid      in   1  ID instruction is J/JAL
//    jr_valid     in   1  ID instruction is JR/JALR
//    id_pc_plus4  in   N  PC+4 of the ID instruction
//    imm16        in  16  branch offset field
//    addr26       in  26  jump index field
//    jr_target    in   N  register value for JR
//    pc           out  N  current fetch address
//    pc_plus4     out  N  pc + 4 (combinational)
//    flush_if     out  1  registered one-cycle kill of IF/ID
//    misalign     out  1  registered one-cycle pulse, JR target bits[1:0]!=0
//  Rev     : 1.0  initial release
// ============================================================================
module pc_sequencer
  import nachi_pc_pkg::*;
#(
  parameter int          N            = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         br_valid,
  input  logic         br_taken,
  input  logic         j_valid,
  input  logic         jr_valid,
  input  logic [N-1:0] id_pc_plus4,
  input  logic [15:0]  imm16,
  input  logic [25:0]  addr26,
  input  logic [N-1:0] jr_target,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_plus4,
  output logic         flush_if,
  output logic         misalign
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  pc_state_t   state_q,    state_d;
  logic [N-1:0] pc_q,      pc_d;
  logic [N-1:0] pend_tgt_q, pend_tgt_d;
  logic        flush_q,    flush_d;
  logic        misalign_q, misalign_d;

  // --------------------------------------------------------------------------
  // Target arithmetic
  // --------------------------------------------------------------------------
  logic [N-1:0] br_target;
  logic [N-1:0] j_target;
  logic [N-1:0] jr_tgt_al;

  branch_target_calc u_tgt (
    .id_pc_plus4 (id_pc_plus4),
    .imm16       (imm16),
    .addr26      (addr26),
    .jr_target   (jr_target),
    .br_target   (br_target),
    .j_target    (j_target),
    .jr_tgt_al   (jr_tgt_al)
  );

  // --------------------------------------------------------------------------
  // Redirect request and priority select (JR > J > taken branch)
  // --------------------------------------------------------------------------
  pc_sel_t      sel;
  logic         req;
  logic [N-1:0] req_tgt;
  logic [N-1:0] pc_inc;

  always_comb begin
    sel = SEL_SEQ;
    if (jr_valid) begin
      sel = SEL_JR;
    end else if (j_valid) begin
      sel = SEL_J;
    end else if (br_valid && br_taken) begin
      sel = SEL_BR;
    end
  end

  // While the flush pulse is high the ID instruction is already dead, so
  // whatever it asks for must not redirect fetch.
  assign req = (sel != SEL_SEQ) && !flush_q;

  always_comb begin
    req_tgt = pc_inc;
    case (sel)
      SEL_BR:  req_tgt = br_target;
      SEL_J:   req_tgt = j_target;
      SEL_JR:  req_tgt = jr_tgt_al;
      default: req_tgt = pc_inc;
    endcase
  end

  // Wraps naturally at 2^32.
  assign pc_inc = pc_q + PC_INC;

  // --------------------------------------------------------------------------
  // Next-state / next-PC
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    flush_d    = 1'b0;
    // Every cycle with a request either takes or latches it, so a JR with a
    // misaligned register value is flagged here regardless of stall.
    misalign_d = req && (sel == SEL_JR) && (jr_target[1:0] != 2'b00);

    case (state_q)
      RUN: begin
        if (req && !stall) begin
          pc_d    = req_tgt;
          flush_d = 1'b1;
        end else if (req && stall) begin
          pend_tgt_d = req_tgt;
          state_d    = PENDING;
        end else if (!stall) begin
          pc_d = pc_inc;
        end
      end

      PENDING: begin
        if (stall) begin
          // ID re-presents the same instruction; keep the newest target.
          if (req) begin
            pend_tgt_d = req_tgt;
          end
        end else begin
          // A request seen in the release cycle is the same instruction,
          // so it wins over the stored copy.
          pc_d    = req ? req_tgt : pend_tgt_q;
          flush_d = 1'b1;
          state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_VECTOR[N-1:0];
      pend_tgt_q <= '0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = pc_inc;
  assign flush_if = flush_q;
  assign misalign = misalign_q;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pc_sequencer
//  Purpose : Self-checking bench for pc_sequencer. A driver issues directed
//            and random stimulus on the falling edge and pushes the expected
//            post-edge outputs from a behavioural model into a queue; a
//            monitor pops and compares after each rising edge.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0040_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_valid;
  logic        br_taken;
  logic        j_valid;
  logic        jr_valid;
  logic [31:0] id_pc_plus4;
  logic [15:0] imm16;
  logic [25:0] addr26;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush_if;
  logic        misalign;

  pc_sequencer #(.N(32), .RESET_VECTOR(RV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .br_valid    (br_valid),
    .br_taken    (br_taken),
    .j_valid     (j_valid),
    .jr_valid    (jr_valid),
    .id_pc_plus4 (id_pc_plus4),
    .imm16       (imm16),
    .addr26      (addr26),
    .jr_target   (jr_target),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .flush_if    (flush_if),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pp4;
    logic        fl;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_flush;
  bit          m_pend;
  logic [31:0] m_tgt;

  function automatic void model_reset();
    m_pc    = RV;
    m_flush = 0;
    m_pend  = 0;
    m_tgt   = 32'h0;
  endfunction

  // Apply one cycle of inputs and record what the outputs must be after the
  // next rising edge.
  task automatic apply(input bit st, input bit bv, input bit bt, input bit jv,
                       input bit jrv, input logic [31:0] idpc,
                       input logic [15:0] im, input logic [25:0] ad,
                       input logic [31:0] jt);
    bit          rq;
    bit          mis;
    logic [31:0] tgt;
    logic [31:0] sx;
    exp_t        e;
    stall = st; br_valid = bv; br_taken = bt; j_valid = jv; jr_valid = jrv;
    id_pc_plus4 = idpc; imm16 = im; addr26 = ad; jr_target = jt;

    rq  = (jrv || jv || (bv && bt)) && !m_flush;
    sx  = 32'($signed(im));
    if (jrv)     tgt = jt & 32'hFFFF_FFFC;
    else if (jv) tgt = (idpc & 32'hF000_0000) | (32'(ad) * 4);
    else         tgt = idpc + sx * 4;
    mis = rq && jrv && (jt % 4 != 0);

    if (!m_pend) begin
      if (rq && !st)      begin m_pc = tgt; m_flush = 1; end
      else if (rq && st)  begin m_tgt = tgt; m_pend = 1; m_flush = 0; end
      else if (!st)       begin m_pc = m_pc + 4; m_flush = 0; end
      else                m_flush = 0;
    end else begin
      if (st) begin
        if (rq) m_tgt = tgt;
        m_flush = 0;
      end else begin
        m_pc    = rq ? tgt : m_tgt;
        m_flush = 1;
        m_pend  = 0;
      end
    end
    e.pc = m_pc; e.pp4 = m_pc + 4; e.fl = m_flush; e.mis = mis;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit st, input bit bv, input bit bt, input bit jv,
                     input bit jrv, input logic [31:0] idpc,
                     input logic [15:0] im, input logic [25:0] ad,
                     input logic [31:0] jt);
    @(negedge clk);
    apply(st, bv, bt, jv, jrv, idpc, im, ad, jt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
  endtask

  // Asynchronous reset asserted between edges; pc must return immediately.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pc !== RV || flush_if !== 1'b0 || misalign !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset pc=%h fl=%b mis=%b required pc=%h fl=0 mis=0",
               pc, flush_if, misalign, RV);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
  endtask

  // Monitor: outputs are meaningful every cycle out of reset.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (pc !== e.pc || pc_plus4 !== e.pp4 || flush_if !== e.fl ||
          misalign !== e.mis) begin
        n_bad++;
        $display("FAIL cycle_out t=%0t got pc=%h pp4=%h fl=%b mis=%b required pc=%h pp4=%h fl=%b mis=%b",
                 $time, pc, pc_plus4, flush_if, misalign, e.pc, e.pp4, e.fl, e.mis);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    stall = 0; br_valid = 0; br_taken = 0; j_valid = 0; jr_valid = 0;
    id_pc_plus4 = 0; imm16 = 0; addr26 = 0; jr_target = 0;
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (pc !== RV || flush_if !== 1'b0 || misalign !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state pc=%h fl=%b mis=%b required pc=%h fl=0 mis=0",
               pc, flush_if, misalign, RV);
    end
    rst_n = 1'b1;
    apply(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    idle(2);

    // Backward branch; the repeat while flushing must be ignored.
    cyc(0, 1, 1, 0, 0, 32'h0040_0010, 16'hFFFC, 26'h0, 32'h0);
    cyc(0, 1, 1, 0, 0, 32'h0040_0010, 16'hFFFC, 26'h0, 32'h0);
    idle(2);

    // Jump with a simultaneous taken branch: jump wins.
    cyc(0, 1, 1, 1, 0, 32'h1000_0004, 16'h0040, 26'h000_0100, 32'h0);
    idle(2);

    // Misaligned JR under a 3-cycle stall, then release.
    cyc(1, 0, 0, 0, 1, 32'h0, 16'h0, 26'h0, 32'h0000_2003);
    cyc(1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    cyc(1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    idle(3);

    // Reset while PENDING discards the stored target.
    cyc(1, 0, 0, 0, 1, 32'h0, 16'h0, 26'h0, 32'h0000_3000);
    cyc(1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    do_reset();
    idle(3);

    // PC wrap.
    cyc(0, 0, 0, 0, 1, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC);
    idle(3);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      bit st, bv, bt, jv, jrv;
      st  = ($urandom_range(0, 3) == 0);
      bv  = ($urandom_range(0, 3) == 0);
      bt  = $urandom_range(0, 1) == 1;
      jv  = ($urandom_range(0, 7) == 0);
      jrv = ($urandom_range(0, 7) == 0);
      cyc(st, bv, bt, jv, jrv, $urandom() & 32'hFFFF_FFFC, 16'($urandom()),
          26'($urandom()), $urandom());
      if (i == 1500) do_reset();
    end
    idle(2);

    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pc_sequencer
`default_nettype wire
